// File: rtl/subdiv_pkg.sv
// subdiv_pkg: shared types and constants for the subdivision stage sequencer
package subdiv_pkg;
    localparam int ADDR_W          = 9;
    localparam int NUM_STAGES_DFLT = 3;
    localparam int TIMER_W         = 17;
    localparam int STAGE_NBR       = 0;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERROR
    } seq_state_t;
    typedef struct packed {
        logic              en;
        logic [3:0]        we;
        logic [ADDR_W-1:0] a;
        logic [31:0]       di;
    } ram_req_t;
endpackage

// File: rtl/ram_port_mux.sv
// ram_port_mux: selects one stage's RAM request, or an all-zero idle request
module ram_port_mux
    import subdiv_pkg::*;
#(
    parameter int N  = 3,
    parameter int SW = 2
) (
    input  ram_req_t [N-1:0]  req,
    input  logic     [SW-1:0] sel,
    input  logic              force_idle,
    output ram_req_t          grant
);
    assign grant = force_idle ? '0 : req[sel];
endmodule

// File: rtl/subdiv_sequencer.sv
// subdiv_sequencer: launches pipeline stages in order, owns the shared RAM grant, watchdogs each stage
module subdiv_sequencer
    import subdiv_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int NUM_STAGES  = NUM_STAGES_DFLT,
    parameter int ACK_TIMEOUT = 8,
    parameter int RUN_TIMEOUT = 65535,
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    output logic [NUM_STAGES-1:0]                 stage_start,
    input  logic [NUM_STAGES-1:0]                 stage_busy,
    input  logic [NUM_STAGES-1:0]                 s_obj_en,
    input  logic [NUM_STAGES-1:0][3:0]            s_obj_we,
    input  logic [NUM_STAGES-1:0][ADDR_WIDTH-1:0] s_obj_a,
    input  logic [NUM_STAGES-1:0][31:0]           s_obj_di,
    input  logic [NUM_STAGES-1:0]                 s_nbr_en,
    input  logic [NUM_STAGES-1:0][3:0]            s_nbr_we,
    input  logic [NUM_STAGES-1:0][ADDR_WIDTH-1:0] s_nbr_a,
    input  logic [NUM_STAGES-1:0][31:0]           s_nbr_di,
    output logic                                  RAM_OBJ_EN,
    output logic [3:0]                            RAM_OBJ_WE,
    output logic [ADDR_WIDTH-1:0]                 RAM_OBJ_A,
    output logic [31:0]                           RAM_OBJ_Di,
    output logic                                  RAM_NBR_EN,
    output logic [3:0]                            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0]                 RAM_NBR_A,
    output logic [31:0]                           RAM_NBR_Di,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [SW-1:0]                         err_stage,
    output logic [SW-1:0]                         cur_stage
);
    localparam logic [TIMER_W-1:0] ACK_LAST   = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RUN_LAST   = TIMER_W'(RUN_TIMEOUT - 1);
    localparam logic [SW-1:0]      LAST_STAGE = SW'(NUM_STAGES - 1);
    seq_state_t state, state_n;
    logic [TIMER_W-1:0] timer, timer_n, timer_inc;
    logic [SW-1:0] cur_n, errs_n;
    logic grant_valid, gv_n, busy_n, err_n, fault;
    ram_req_t [NUM_STAGES-1:0] obj_req, nbr_req;
    ram_req_t obj_grant, nbr_grant;
    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_req
            assign obj_req[g] = {s_obj_en[g], s_obj_we[g], s_obj_a[g], s_obj_di[g]};
            assign nbr_req[g] = {s_nbr_en[g], s_nbr_we[g], s_nbr_a[g], s_nbr_di[g]};
        end
    endgenerate
    ram_port_mux #(.N(NUM_STAGES), .SW(SW)) u_obj_mux (
        .req        (obj_req),
        .sel        (cur_stage),
        .force_idle (!grant_valid),
        .grant      (obj_grant)
    );
    ram_port_mux #(.N(NUM_STAGES), .SW(SW)) u_nbr_mux (
        .req        (nbr_req),
        .sel        (cur_stage),
        .force_idle (!grant_valid),
        .grant      (nbr_grant)
    );
    assign {RAM_OBJ_EN, RAM_OBJ_WE, RAM_OBJ_A, RAM_OBJ_Di} = obj_grant;
    assign {RAM_NBR_EN, RAM_NBR_WE, RAM_NBR_A, RAM_NBR_Di} = nbr_grant;
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;
    always_comb begin
        stage_start = (state == S_LAUNCH) ? (NUM_STAGES'(1) << cur_stage) : '0;
        done        = state == S_DONE;
        state_n     = state;
        timer_n     = '0;
        cur_n       = cur_stage;
        gv_n        = grant_valid;
        busy_n      = busy;
        err_n       = error;
        errs_n      = err_stage;
        fault       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    cur_n   = SW'(STAGE_NBR);
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                gv_n    = 1'b1;
                state_n = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (stage_busy[cur_stage]) state_n = S_RUN;
                else if (timer == ACK_LAST) fault = 1'b1;
                else timer_n = timer_inc;
            end
            S_RUN: begin
                if (!stage_busy[cur_stage]) begin
                    gv_n    = 1'b0;
                    state_n = S_NEXT;
                end else if (timer == RUN_LAST) fault = 1'b1;
                else timer_n = timer_inc;
            end
            S_NEXT: begin
                if (cur_stage == LAST_STAGE) begin
                    busy_n  = 1'b0;
                    state_n = S_DONE;
                end else begin
                    cur_n   = cur_stage + 1'b1;
                    state_n = S_LAUNCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // abort outranks both watchdogs and normal completion
        if (fault || (abort && state != S_IDLE)) begin
            state_n = S_ERROR;
            timer_n = '0;
            cur_n   = cur_stage;
            gv_n    = 1'b0;
            busy_n  = 1'b0;
            err_n   = 1'b1;
            errs_n  = cur_stage;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            cur_stage   <= '0;
            grant_valid <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            err_stage   <= '0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            cur_stage   <= cur_n;
            grant_valid <= gv_n;
            busy        <= busy_n;
            error       <= err_n;
            err_stage   <= errs_n;
        end
    end
endmodule

// File: tb/tb_subdiv_sequencer.sv
// tb_subdiv_sequencer: randomized runs checked against a cycle schedule derived from stage durations
module tb_subdiv_sequencer;
    localparam int NS   = 3;
    localparam int AW   = 9;
    localparam int ACK  = 8;
    localparam int RUNT = 20;
    logic clk = 1'b0;
    logic rst, start, abort;
    logic eng_rst = 1'b0;
    logic [NS-1:0] stage_start, stage_busy;
    logic [NS-1:0] s_obj_en, s_nbr_en;
    logic [NS-1:0][3:0] s_obj_we, s_nbr_we;
    logic [NS-1:0][AW-1:0] s_obj_a, s_nbr_a;
    logic [NS-1:0][31:0] s_obj_di, s_nbr_di;
    logic RAM_OBJ_EN, RAM_NBR_EN;
    logic [3:0] RAM_OBJ_WE, RAM_NBR_WE;
    logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A;
    logic [31:0] RAM_OBJ_Di, RAM_NBR_Di;
    logic busy, done, error;
    logic [1:0] err_stage, cur_stage;
    int errors = 0;
    int checks = 0;
    int eng_d[NS];
    int eng_l[NS];
    int pend[NS];
    int rem[NS];
    always #5 clk = ~clk;
    subdiv_sequencer #(
        .ADDR_WIDTH(AW), .NUM_STAGES(NS), .ACK_TIMEOUT(ACK), .RUN_TIMEOUT(RUNT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .stage_start(stage_start), .stage_busy(stage_busy),
        .s_obj_en(s_obj_en), .s_obj_we(s_obj_we), .s_obj_a(s_obj_a), .s_obj_di(s_obj_di),
        .s_nbr_en(s_nbr_en), .s_nbr_we(s_nbr_we), .s_nbr_a(s_nbr_a), .s_nbr_di(s_nbr_di),
        .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_WE(RAM_OBJ_WE), .RAM_OBJ_A(RAM_OBJ_A), .RAM_OBJ_Di(RAM_OBJ_Di),
        .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_WE(RAM_NBR_WE), .RAM_NBR_A(RAM_NBR_A), .RAM_NBR_Di(RAM_NBR_Di),
        .busy(busy), .done(done), .error(error), .err_stage(err_stage), .cur_stage(cur_stage)
    );
    // engine models: busy rises eng_d negedges after the pulse (0 = never), stays eng_l negedges (0 = stuck)
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rst || eng_rst) begin
                pend[i] <= 0;
                rem[i] <= 0;
                stage_busy[i] <= 1'b0;
            end else if (stage_start[i]) pend[i] <= eng_d[i];
            else if (pend[i] > 0) begin
                pend[i] <= pend[i] - 1;
                if (pend[i] == 1) begin
                    stage_busy[i] <= 1'b1;
                    rem[i] <= eng_l[i];
                end
            end else if (stage_busy[i] && eng_l[i] != 0) begin
                rem[i] <= rem[i] - 1;
                if (rem[i] == 1) stage_busy[i] <= 1'b0;
            end
        end
    end
    always @(negedge clk) begin
        s_obj_en <= NS'($urandom);
        s_nbr_en <= NS'($urandom);
        s_obj_we <= (NS*4)'($urandom);
        s_nbr_we <= (NS*4)'($urandom);
        s_obj_a  <= (NS*AW)'($urandom);
        s_nbr_a  <= (NS*AW)'($urandom);
        s_obj_di <= {$urandom, $urandom, $urandom};
        s_nbr_di <= {$urandom, $urandom, $urandom};
    end
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask
    task automatic set_eng(input int d0, input int d1, input int d2, input int l0, input int l1, input int l2);
        eng_d[0] = d0; eng_d[1] = d1; eng_d[2] = d2;
        eng_l[0] = l0; eng_l[1] = l1; eng_l[2] = l2;
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".stage_start"}, stage_start, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".error"}, error, 0);
        chk({tag, ".err_stage"}, err_stage, 0);
        chk({tag, ".cur_stage"}, cur_stage, 0);
        chk({tag, ".ram_obj"}, {RAM_OBJ_EN, RAM_OBJ_WE, RAM_OBJ_A, RAM_OBJ_Di}, 0);
        chk({tag, ".ram_nbr"}, {RAM_NBR_EN, RAM_NBR_WE, RAM_NBR_A, RAM_NBR_Di}, 0);
    endtask
    // Cycle 0 is the LAUNCH cycle after start is accepted. Each stage: LAUNCH at ts, RAM granted
    // from ts+1 through its last busy-high sample, then one NEXT cycle; DONE/ERROR lands at cycle e.
    task automatic run_case(input int abort_at, input int rst_at);
        int ts[NS];
        int gend[NS];
        bit launched[NS];
        int t, e, fs, own, gown;
        bit flt;
        logic [NS-1:0] exp_ss;
        t = 0; e = 0; fs = 0; flt = 0;
        for (int i = 0; i < NS; i++) begin
            ts[i] = 0; gend[i] = -1; launched[i] = 0;
        end
        for (int i = 0; i < NS && !flt; i++) begin
            ts[i] = t;
            launched[i] = 1;
            if (eng_d[i] == 0 || eng_d[i] > ACK) begin
                flt = 1; fs = i; gend[i] = t + ACK; e = gend[i] + 1;
            end else if (eng_l[i] == 0 || eng_l[i] > RUNT) begin
                flt = 1; fs = i; gend[i] = t + eng_d[i] + RUNT; e = gend[i] + 1;
            end else begin
                gend[i] = t + eng_d[i] + eng_l[i];
                t = gend[i] + 2;
            end
        end
        if (!flt) e = t;
        if (abort_at >= e) abort_at = -1;
        if (abort_at >= 0) begin
            flt = 1;
            e = abort_at + 1;
            for (int i = 0; i < NS; i++) begin
                if (launched[i] && ts[i] > abort_at) launched[i] = 0;
                if (launched[i]) begin
                    fs = i;
                    if (gend[i] > abort_at) gend[i] = abort_at;
                end
            end
        end
        eng_rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        eng_rst = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= e + 1; c++) begin
            own = 0; gown = -1; exp_ss = '0;
            for (int i = 0; i < NS; i++) begin
                if (launched[i] && ts[i] <= c) own = i;
                if (launched[i] && c >= ts[i] + 1 && c <= gend[i] && c < e) gown = i;
                if (launched[i] && c == ts[i]) exp_ss[i] = 1'b1;
            end
            chk("stage_start", stage_start, exp_ss);
            chk("busy", busy, c < e);
            chk("done", done, !flt && c == e);
            chk("error", error, flt && c >= e);
            if (flt && c >= e) chk("err_stage", err_stage, fs);
            chk("cur_stage", cur_stage, own);
            if (gown >= 0) begin
                chk("ram_obj", {RAM_OBJ_EN, RAM_OBJ_WE, RAM_OBJ_A, RAM_OBJ_Di},
                    {s_obj_en[gown], s_obj_we[gown], s_obj_a[gown], s_obj_di[gown]});
                chk("ram_nbr", {RAM_NBR_EN, RAM_NBR_WE, RAM_NBR_A, RAM_NBR_Di},
                    {s_nbr_en[gown], s_nbr_we[gown], s_nbr_a[gown], s_nbr_di[gown]});
            end else begin
                chk("ram_obj_idle", {RAM_OBJ_EN, RAM_OBJ_WE}, 0);
                chk("ram_nbr_idle", {RAM_NBR_EN, RAM_NBR_WE}, 0);
            end
            if (c == rst_at) begin
                rst = 1'b1;
                start = 1'b1;
                @(posedge clk); #1;
                chk_reset_outputs("mid_rst");
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("rst_start_ignored", busy, 0);
                end
                rst = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                chk("post_rst_idle", busy, 0);
                return;
            end
            abort = (c == abort_at);
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_eng(1, 1, 1, 5, 7, 3);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        run_case(-1, -1);
        set_eng(1, 0, 1, 5, 7, 3);
        run_case(-1, -1);
        set_eng(1, 1, 1, 0, 7, 3);
        run_case(-1, -1);
        set_eng(1, 1, 1, 5, 7, 3);
        run_case(12, -1);
        run_case(-1, -1);
        set_eng(8, 8, 8, 20, 20, 20);
        run_case(-1, -1);
        set_eng(1, 1, 9, 1, 1, 1);
        run_case(-1, -1);
        set_eng(2, 3, 1, 1, 4, 21);
        run_case(-1, -1);
        set_eng(1, 1, 1, 5, 7, 3);
        run_case(-1, 21);
        repeat (16) begin
            int d[NS];
            int l[NS];
            int ab;
            for (int i = 0; i < NS; i++) begin
                d[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9);
                l[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 22);
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : -1;
            set_eng(d[0], d[1], d[2], l[0], l[1], l[2]);
            run_case(ab, -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
